alu_arbiter: RTL and testbench



---
 rtl/alu_arbiter_if.sv | 44 ++++
 rtl/alu_arbiter.sv | 155 +++++++++++++++
 tb/tb_alu_arbiter.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/alu_arbiter_if.sv
// Request/response bus of the shared ALU: two requester channels in, one tagged
// response channel out, plus the busy indication.
interface alu_arbiter_if #(
    parameter int W = 4
);
    logic         req0_valid;
    logic [2:0]   req0_op;
    logic [W-1:0] req0_a;
    logic [W-1:0] req0_b;
    logic         req0_ready;

    logic         req1_valid;
    logic [2:0]   req1_op;
    logic [W-1:0] req1_a;
    logic [W-1:0] req1_b;
    logic         req1_ready;

    logic         rsp_valid;
    logic         rsp_ready;
    logic         rsp_id;
    logic [W-1:0] rsp_data;
    logic         rsp_err;
    logic         busy;

    // Requesters and response consumer side.
    modport master (
        output req0_valid, req0_op, req0_a, req0_b,
        input  req0_ready,
        output req1_valid, req1_op, req1_a, req1_b,
        input  req1_ready,
        input  rsp_valid, rsp_id, rsp_data, rsp_err, busy,
        output rsp_ready
    );

    // Arbitrated ALU side.
    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b,
        output req0_ready,
        input  req1_valid, req1_op, req1_a, req1_b,
        output req1_ready,
        output rsp_valid, rsp_id, rsp_data, rsp_err, busy,
        input  rsp_ready
    );
endinterface

// File: rtl/alu_arbiter.sv
// One W-bit ALU shared by two requesters under round-robin arbitration.
// One operation in flight; division is restoring, one quotient bit per cycle.
module alu_arbiter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    alu_arbiter_if.slave bus
);
    localparam int CW = (W > 1) ? $clog2(W) : 1;
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_DIV,
        S_RESP
    } state_t;

    state_t        r_state;
    logic          r_ptr;       // 0: requester 0 favoured, 1: requester 1 favoured
    logic          r_id;
    logic [2:0]    r_op;
    logic [W-1:0]  r_a;
    logic [W-1:0]  r_b;
    logic [W-1:0]  r_rem;
    logic [W-1:0]  r_quo;
    logic [CW-1:0] r_cnt;
    logic          r_rsp_valid;
    logic [W-1:0]  r_data;
    logic          r_rsp_err;
    logic          r_busy;

    logic          w_idle;
    logic          w_gnt0;
    logic          w_gnt1;
    logic [W-1:0]  w_alu;
    logic [W:0]    w_div_sh;
    logic          w_div_ge;
    logic [W-1:0]  w_div_diff;
    logic [W-1:0]  w_rem_nxt;
    logic [W-1:0]  w_quo_nxt;

    // Grant: only in IDLE and out of reset; contention resolved by the RR pointer.
    always_comb begin
        w_idle = rst_n && (r_state == S_IDLE);
        w_gnt0 = w_idle && bus.req0_valid && (!bus.req1_valid || !r_ptr);
        w_gnt1 = w_idle && bus.req1_valid && (!bus.req0_valid || r_ptr);
    end

    assign bus.req0_ready = w_gnt0;
    assign bus.req1_ready = w_gnt1;
    assign bus.rsp_valid  = r_rsp_valid;
    assign bus.rsp_id     = r_id;
    assign bus.rsp_data   = r_data;
    assign bus.rsp_err    = r_rsp_err;
    assign bus.busy       = r_busy;

    // Single-cycle ops on the latched operands; results wrap to W bits.
    always_comb begin
        w_alu = '0;
        case (r_op)
            3'd0:    w_alu = r_a + r_b;
            3'd1:    w_alu = r_a - r_b;
            3'd2:    w_alu = r_a * r_b;
            3'd4:    w_alu = r_a | r_b;
            3'd5:    w_alu = r_a & r_b;
            3'd6:    w_alu = r_a ^ r_b;
            3'd7:    w_alu = ~(r_a ^ r_b);
            default: w_alu = '0;
        endcase
    end

    // One restoring-division step: shift in the next dividend bit, trial-subtract.
    // The remainder stays below b, so the low W bits of the difference are exact.
    always_comb begin
        w_div_sh   = {r_rem, r_quo[W-1]};
        w_div_ge   = (w_div_sh >= {1'b0, r_b});
        w_div_diff = w_div_sh[W-1:0] - r_b;
        w_rem_nxt  = w_div_ge ? w_div_diff : w_div_sh[W-1:0];
        w_quo_nxt  = {r_quo[W-2:0], w_div_ge};
    end

    // Control FSM with registered response outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_ptr       <= 1'b0;
            r_id        <= 1'b0;
            r_op        <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_rem       <= '0;
            r_quo       <= '0;
            r_cnt       <= '0;
            r_rsp_valid <= 1'b0;
            r_data      <= '0;
            r_rsp_err   <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_gnt0 || w_gnt1) begin
                        r_op    <= w_gnt1 ? bus.req1_op : bus.req0_op;
                        r_a     <= w_gnt1 ? bus.req1_a  : bus.req0_a;
                        r_b     <= w_gnt1 ? bus.req1_b  : bus.req0_b;
                        r_id    <= w_gnt1;
                        r_ptr   <= ~w_gnt1;
                        r_busy  <= 1'b1;
                        r_state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (r_op == 3'd3) begin
                        if (r_b == '0) begin
                            r_data      <= '1;
                            r_rsp_err   <= 1'b1;
                            r_rsp_valid <= 1'b1;
                            r_state     <= S_RESP;
                        end else begin
                            r_rem   <= '0;
                            r_quo   <= r_a;
                            r_cnt   <= '0;
                            r_state <= S_DIV;
                        end
                    end else begin
                        r_data      <= w_alu;
                        r_rsp_err   <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_state     <= S_RESP;
                    end
                end
                S_DIV: begin
                    r_rem <= w_rem_nxt;
                    r_quo <= w_quo_nxt;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == LAST) begin
                        r_data      <= w_quo_nxt;
                        r_rsp_err   <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_state     <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (bus.rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed plus randomized bench for alu_arbiter against an arithmetic reference
// model and a round-robin grant model.
module tb_alu_arbiter;
    localparam int W = 4;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_err;
    bit   ptr_m;      // 0: requester 0 wins next contention

    alu_arbiter_if #(.W(W)) bus ();

    alu_arbiter #(.W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference result {err, data} from plain integer arithmetic.
    function automatic logic [4:0] ref_alu(input int op, input int a, input int b);
        int r;
        bit e;
        e = 1'b0;
        case (op)
            0: r = (a + b) % 16;
            1: r = (a - b + 16) % 16;
            2: r = (a * b) % 16;
            3: if (b == 0) begin r = 15; e = 1'b1; end else r = a / b;
            4: r = a | b;
            5: r = a & b;
            6: r = a ^ b;
            default: r = (~(a ^ b)) & 15;
        endcase
        return {e, 4'(r)};
    endfunction

    // Present a request pattern from an idle negedge, follow it through the
    // response handshake, and return at a negedge with the DUT idle again.
    task automatic transact(input bit v0, input bit v1,
                            input int o0, input int a0, input int b0,
                            input int o1, input int a1, input int b1,
                            input int hold);
        int g, op, a, b, lat, cnt;
        logic [4:0] exp;
        g   = (v0 && v1) ? int'(ptr_m) : (v1 ? 1 : 0);
        op  = g ? o1 : o0;
        a   = g ? a1 : a0;
        b   = g ? b1 : b0;
        exp = ref_alu(op, a, b);
        lat = (op == 3 && b != 0) ? W + 1 : 1;

        bus.req0_valid = v0; bus.req0_op = 3'(o0); bus.req0_a = 4'(a0); bus.req0_b = 4'(b0);
        bus.req1_valid = v1; bus.req1_op = 3'(o1); bus.req1_a = 4'(a1); bus.req1_b = 4'(b1);
        bus.rsp_ready  = (hold == 0);
        #1;
        chk("req0_ready_grant", 32'(bus.req0_ready), 32'(g == 0));
        chk("req1_ready_grant", 32'(bus.req1_ready), 32'(g == 1));
        @(posedge clk);
        ptr_m = (g == 0);
        @(negedge clk);
        // Scramble requester inputs after the handshake: must have no effect.
        bus.req0_valid = 1'($urandom); bus.req0_op = 3'($urandom);
        bus.req0_a = 4'($urandom); bus.req0_b = 4'($urandom);
        bus.req1_valid = 1'($urandom); bus.req1_op = 3'($urandom);
        bus.req1_a = 4'($urandom); bus.req1_b = 4'($urandom);
        cnt = 0;
        while (!bus.rsp_valid && cnt < 20) begin
            chk("busy_in_flight", 32'(bus.busy), 32'd1);
            chk("ready_in_flight", 32'(bus.req0_ready | bus.req1_ready), 32'd0);
            @(negedge clk);
            cnt++;
        end
        chk("rsp_latency", 32'(cnt), 32'(lat));
        chk("rsp_id", 32'(bus.rsp_id), 32'(g));
        chk("rsp_data", 32'(bus.rsp_data), 32'(exp[3:0]));
        chk("rsp_err", 32'(bus.rsp_err), 32'(exp[4]));
        chk("busy_at_rsp", 32'(bus.busy), 32'd1);
        for (int i = 0; i < hold; i++) begin
            bus.req0_valid = 1'b1;
            bus.req1_valid = 1'b1;
            @(negedge clk);
            chk("hold_valid", 32'(bus.rsp_valid), 32'd1);
            chk("hold_data", 32'(bus.rsp_data), 32'(exp[3:0]));
            chk("hold_id", 32'(bus.rsp_id), 32'(g));
            chk("hold_ready", 32'(bus.req0_ready | bus.req1_ready), 32'd0);
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        chk("rsp_valid_drop", 32'(bus.rsp_valid), 32'd0);
        chk("busy_drop", 32'(bus.busy), 32'd0);
    endtask

    initial begin
        n_checks = 0;
        n_err    = 0;
        ptr_m    = 1'b0;
        rst_n    = 1'b0;
        bus.req0_valid = 1'b1; bus.req0_op = '0; bus.req0_a = '0; bus.req0_b = '0;
        bus.req1_valid = 1'b1; bus.req1_op = '0; bus.req1_a = '0; bus.req1_b = '0;
        bus.rsp_ready  = 1'b1;

        // Reset state, readies held low while in reset even with valid requests.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_rsp_id", 32'(bus.rsp_id), 32'd0);
        chk("rst_rsp_data", 32'(bus.rsp_data), 32'd0);
        chk("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_ready", 32'(bus.req0_ready | bus.req1_ready), 32'd0);
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);

        // Add, add overflow, sub/mul wrap, divide, divide by zero.
        transact(1, 0, 0, 10, 1, 0, 0, 0, 0);
        transact(1, 0, 0, 15, 1, 0, 0, 0, 0);
        transact(0, 1, 0, 0, 0, 1, 3, 5, 0);
        transact(0, 1, 0, 0, 0, 2, 7, 5, 0);
        transact(1, 0, 3, 10, 3, 0, 0, 0, 0);
        transact(1, 0, 3, 10, 0, 0, 0, 0, 0);
        transact(0, 1, 0, 0, 0, 3, 15, 1, 0);

        // Continuous contention alternates; lone requester always wins.
        for (int i = 0; i < 4; i++) transact(1, 1, 4, 12, 10, 5, 12, 10, 0);
        for (int i = 0; i < 3; i++) transact(0, 1, 0, 0, 0, 6, i, 9, 0);
        transact(1, 1, 7, 5, 3, 0, 1, 1, 0);

        // Backpressure for 5 cycles.
        transact(1, 0, 2, 6, 6, 0, 0, 0, 5);

        // Reset in the middle of a divide: nothing is emitted.
        bus.req0_valid = 1'b1; bus.req0_op = 3'd3; bus.req0_a = 4'd10; bus.req0_b = 4'd3;
        bus.req1_valid = 1'b0;
        @(posedge clk);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("middiv_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("middiv_busy", 32'(bus.busy), 32'd0);
        chk("middiv_ready", 32'(bus.req0_ready | bus.req1_ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("middiv_no_rsp", 32'(bus.rsp_valid), 32'd0);
        end
        ptr_m = 1'b0;
        rst_n = 1'b1;
        transact(1, 1, 0, 2, 3, 1, 9, 9, 0);

        // Randomized traffic against the model.
        for (int i = 0; i < 40; i++) begin
            int sel;
            sel = int'($urandom_range(0, 2));
            transact(sel != 1, sel != 0,
                     int'($urandom_range(0, 7)), int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                     int'($urandom_range(0, 7)), int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                     int'($urandom_range(0, 2)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
